// File: rtl/pic_pkg.sv
// -----------------------------------------------------------------------------
// pic_pkg
// Shared definitions for the 8259A PIC acknowledge path.
//   - inta_state_e : acknowledge FSM states (IDLE, P1, GAP, P2)
//   - VEC_W        : width of an IR index
//   - SPURIOUS_VEC : IR index reported when no interrupt was pending at INTA
//   - VEC_BASE_*   : 8086 vector format, ICW2[7:3] supplies the upper bits
//   - vector_byte  : assembles the 8086 vector byte from base and IR index
// -----------------------------------------------------------------------------
package pic_pkg;

    localparam int VEC_W = 3;
    localparam logic [VEC_W-1:0] SPURIOUS_VEC = 3'b111;

    // 8086 mode: vector = {ICW2[7:3], IR index}
    localparam int VEC_BASE_MSB = 7;
    localparam int VEC_BASE_LSB = 3;
    localparam int VEC_BASE_W   = VEC_BASE_MSB - VEC_BASE_LSB + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,  // waiting for first INTA pulse
        P1   = 2'd1,  // first INTA pulse low
        GAP  = 2'd2,  // between the two pulses
        P2   = 2'd3   // second INTA pulse low, vector on the bus
    } inta_state_e;

    function automatic logic [7:0] vector_byte(input logic [VEC_BASE_W-1:0] base,
                                               input logic [VEC_W-1:0]      vec);
        return {base, vec};
    endfunction

endpackage

// File: rtl/inta_sync.sv
// -----------------------------------------------------------------------------
// inta_sync
// Synchronises the asynchronous, active-low INTA_N into the clk domain and
// detects its edges. Flops reset to 1 so an idle-high line never produces a
// false edge when reset is released.
// Ports:
//   clk       i  system clock
//   reset     i  asynchronous active-high reset
//   inta_n_i  i  raw CPU acknowledge (active-low, asynchronous)
//   fall_o    o  synchronised 1->0 transition seen this cycle
//   rise_o    o  synchronised 0->1 transition seen this cycle
// -----------------------------------------------------------------------------
module inta_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic inta_n_i,
    output logic fall_o,
    output logic rise_o
);

    // Fewer than two stages would not give metastability protection.
    localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic [STAGES-1:0] sync_q;
    logic              prev_q;
    logic              sync_n;

    assign sync_n = sync_q[STAGES-1];

    // NOTE: sequential state uses non-blocking assignments so every flop in the
    // chain samples the value from before this edge, forming a true shift chain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], inta_n_i};
            prev_q <= sync_n;
        end
    end

    // A single sync_n bit means fall and rise are mutually exclusive.
    assign fall_o = prev_q & ~sync_n;
    assign rise_o = ~prev_q & sync_n;

endmodule

// File: rtl/inta_sequencer.sv
// -----------------------------------------------------------------------------
// inta_sequencer
// Sits downstream of priority_resolver. Forwards the pending interrupt to the
// CPU and runs the 8086 two-pulse INTA cycle: ACK1 on the first pulse, vector
// byte on the bus during the second, optional automatic EOI afterwards.
// All strobes and bus outputs are registered.
// Ports:
//   clk        i  system clock
//   reset      i  asynchronous active-high reset
//   INTA_N     i  CPU acknowledge, active-low, asynchronous
//   INT        i  pending-interrupt flag from resolver
//   INT_VEC    i  winning IR index from resolver
//   ICW2       i  vector base (bits [7:3] used)
//   AEOI       i  automatic-EOI mode enable
//   INT_OUT    o  interrupt request to CPU
//   FREEZE     o  acknowledge in progress, resolver holds its vector
//   ACK1       o  strobe: set ISR[vec], clear IRR[vec]
//   ACK2       o  strobe at start of the second pulse
//   AEOI_STB   o  strobe requesting non-specific EOI
//   EOI_LEVEL  o  IR index accompanying AEOI_STB (0 otherwise)
//   DATA_OUT   o  vector byte (0 when not driven)
//   DATA_OE    o  data bus drive enable
// -----------------------------------------------------------------------------
module inta_sequencer
    import pic_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             INTA_N,
    input  logic             INT,
    input  logic [VEC_W-1:0] INT_VEC,
    input  logic [7:0]       ICW2,
    input  logic             AEOI,
    output logic             INT_OUT,
    output logic             FREEZE,
    output logic             ACK1,
    output logic             ACK2,
    output logic             AEOI_STB,
    output logic [VEC_W-1:0] EOI_LEVEL,
    output logic [7:0]       DATA_OUT,
    output logic             DATA_OE
);

    logic fall;
    logic rise;

    inta_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .reset    (reset),
        .inta_n_i (INTA_N),
        .fall_o   (fall),
        .rise_o   (rise)
    );

    // ICW2[2:0] carries no meaning in 8086 mode.
    logic unused_icw2_low;
    assign unused_icw2_low = ^ICW2[VEC_BASE_LSB-1:0];

    logic [VEC_BASE_W-1:0] vec_base;
    assign vec_base = ICW2[VEC_BASE_MSB:VEC_BASE_LSB];

    inta_state_e      state_q,     state_d;
    logic [VEC_W-1:0] vec_q,       vec_d;
    logic             spurious_q,  spurious_d;
    logic             int_out_q,   int_out_d;
    logic             ack1_q,      ack1_d;
    logic             ack2_q,      ack2_d;
    logic             aeoi_stb_q,  aeoi_stb_d;
    logic [VEC_W-1:0] eoi_level_q, eoi_level_d;
    logic [7:0]       data_out_q,  data_out_d;
    logic             data_oe_q,   data_oe_d;

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        spurious_d  = spurious_q;
        int_out_d   = 1'b0;
        ack1_d      = 1'b0;
        ack2_d      = 1'b0;
        aeoi_stb_d  = 1'b0;
        eoi_level_d = '0;
        data_out_d  = '0;
        data_oe_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                int_out_d = INT;
                if (fall) begin
                    // Capture now; later resolver changes cannot affect this cycle.
                    vec_d      = INT ? INT_VEC : SPURIOUS_VEC;
                    spurious_d = ~INT;
                    ack1_d     = INT;
                    int_out_d  = 1'b0;
                    state_d    = P1;
                end
            end

            P1: begin
                if (rise) begin
                    state_d = GAP;
                end
            end

            GAP: begin
                if (fall) begin
                    ack2_d     = 1'b1;
                    data_out_d = vector_byte(vec_base, vec_q);
                    data_oe_d  = 1'b1;
                    state_d    = P2;
                end
            end

            P2: begin
                if (rise) begin
                    // Bus released; a spurious cycle never set an ISR bit, so no EOI.
                    if (AEOI && !spurious_q) begin
                        aeoi_stb_d  = 1'b1;
                        eoi_level_d = vec_q;
                    end
                    state_d = IDLE;
                end else begin
                    // ICW2 is followed live while the vector is on the bus.
                    data_out_d = vector_byte(vec_base, vec_q);
                    data_oe_d  = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            vec_q       <= '0;
            spurious_q  <= 1'b0;
            int_out_q   <= 1'b0;
            ack1_q      <= 1'b0;
            ack2_q      <= 1'b0;
            aeoi_stb_q  <= 1'b0;
            eoi_level_q <= '0;
            data_out_q  <= '0;
            data_oe_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            spurious_q  <= spurious_d;
            int_out_q   <= int_out_d;
            ack1_q      <= ack1_d;
            ack2_q      <= ack2_d;
            aeoi_stb_q  <= aeoi_stb_d;
            eoi_level_q <= eoi_level_d;
            data_out_q  <= data_out_d;
            data_oe_q   <= data_oe_d;
        end
    end

    assign INT_OUT   = int_out_q;
    assign FREEZE    = (state_q != IDLE);
    assign ACK1      = ack1_q;
    assign ACK2      = ack2_q;
    assign AEOI_STB  = aeoi_stb_q;
    assign EOI_LEVEL = eoi_level_q;
    assign DATA_OUT  = data_out_q;
    assign DATA_OE   = data_oe_q;

endmodule

// File: tb/tb_inta_sequencer.sv
// -----------------------------------------------------------------------------
// tb_inta_sequencer
// Directed bench for inta_sequencer. Each acknowledge sequence is driven with
// fixed pulse lengths; a per-cycle sampler gathers strobe counts, first-strobe
// cycle indices and bus contents, which are compared against hand-derived
// values. With SYNC_STAGES = 2 every INTA_N edge acts 3 cycles later.
// -----------------------------------------------------------------------------
module tb_inta_sequencer;

    localparam int SYNC_STAGES = 2;
    localparam int LAT         = SYNC_STAGES + 1;

    logic       clk = 1'b0;
    logic       reset;
    logic       INTA_N;
    logic       INT;
    logic [2:0] INT_VEC;
    logic [7:0] ICW2;
    logic       AEOI;
    logic       INT_OUT;
    logic       FREEZE;
    logic       ACK1;
    logic       ACK2;
    logic       AEOI_STB;
    logic [2:0] EOI_LEVEL;
    logic [7:0] DATA_OUT;
    logic       DATA_OE;

    inta_sequencer #(
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .INTA_N    (INTA_N),
        .INT       (INT),
        .INT_VEC   (INT_VEC),
        .ICW2      (ICW2),
        .AEOI      (AEOI),
        .INT_OUT   (INT_OUT),
        .FREEZE    (FREEZE),
        .ACK1      (ACK1),
        .ACK2      (ACK2),
        .AEOI_STB  (AEOI_STB),
        .EOI_LEVEL (EOI_LEVEL),
        .DATA_OUT  (DATA_OUT),
        .DATA_OE   (DATA_OE)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // Per-sequence statistics
    int         cyc;
    int         ack1_cnt, ack2_cnt, aeoi_cnt, oe_cnt, freeze_cnt;
    int         data_err, busy_int, lvl_err;
    int         ack1_at, ack2_at, aeoi_at;
    logic [2:0] aeoi_lvl;
    logic [7:0] exp_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic clear_stats();
        cyc = 0;
        ack1_cnt = 0; ack2_cnt = 0; aeoi_cnt = 0; oe_cnt = 0; freeze_cnt = 0;
        data_err = 0; busy_int = 0; lvl_err = 0;
        ack1_at = -1; ack2_at = -1; aeoi_at = -1;
        aeoi_lvl = 3'd0;
    endtask

    // One clock, then sample outputs 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (ACK1) begin
            ack1_cnt++;
            if (ack1_at < 0) ack1_at = cyc;
        end
        if (ACK2) begin
            ack2_cnt++;
            if (ack2_at < 0) ack2_at = cyc;
        end
        if (AEOI_STB) begin
            aeoi_cnt++;
            aeoi_lvl = EOI_LEVEL;
            if (aeoi_at < 0) aeoi_at = cyc;
        end else if (EOI_LEVEL != 3'd0) begin
            lvl_err++;
        end
        if (DATA_OE) begin
            oe_cnt++;
            if (DATA_OUT !== exp_data) data_err++;
        end else if (DATA_OUT != 8'h00) begin
            data_err++;
        end
        if (FREEZE) freeze_cnt++;
        if (FREEZE && INT_OUT) busy_int++;
    endtask

    // Full two-pulse acknowledge. Optionally changes INT_VEC during the gap.
    task automatic do_ack(input int lo1, input int gap, input int lo2, input int tail,
                          input logic chg, input logic [2:0] new_vec);
        clear_stats();
        INTA_N = 1'b0;
        repeat (lo1) tick();
        INTA_N = 1'b1;
        if (chg) INT_VEC = new_vec;
        repeat (gap) tick();
        INTA_N = 1'b0;
        repeat (lo2) tick();
        INTA_N = 1'b1;
        repeat (tail) tick();
    endtask

    initial begin
        reset   = 1'b1;
        INTA_N  = 1'b1;
        INT     = 1'b1;
        INT_VEC = 3'd3;
        ICW2    = 8'h40;
        AEOI    = 1'b0;
        exp_data = 8'h00;
        clear_stats();

        // ---- 1. reset, then idle request forwarding --------------------------
        #2;
        check("rst_int_out",  {31'd0, INT_OUT},  32'd0);
        check("rst_freeze",   {31'd0, FREEZE},   32'd0);
        check("rst_data_oe",  {31'd0, DATA_OE},  32'd0);
        check("rst_data_out", {24'd0, DATA_OUT}, 32'd0);
        check("rst_strobes",  {29'd0, ACK1, ACK2, AEOI_STB}, 32'd0);
        tick(); tick();
        reset = 1'b0;
        check("int_out_pre", {31'd0, INT_OUT}, 32'd0);
        tick();
        check("int_out_lat1", {31'd0, INT_OUT}, 32'd1);
        reset = 1'b1;
        #1;
        check("int_out_async_rst", {31'd0, INT_OUT}, 32'd0);
        tick();
        reset = 1'b0;
        tick(); tick();

        // ---- 2. normal cycle, vector 5, base 0x40 -----------------------------
        INT_VEC  = 3'd5;
        exp_data = 8'h45;
        do_ack(4, 4, 4, 6, 1'b0, 3'd0);
        check("n_ack1_at",    ack1_at,    LAT);
        check("n_ack1_cnt",   ack1_cnt,   1);
        check("n_ack2_at",    ack2_at,    8 + LAT);
        check("n_ack2_cnt",   ack2_cnt,   1);
        check("n_oe_cnt",     oe_cnt,     4);
        check("n_data_err",   data_err,   0);
        check("n_aeoi_cnt",   aeoi_cnt,   0);
        check("n_busy_int",   busy_int,   0);
        check("n_freeze_cnt", freeze_cnt, 12);
        check("n_lvl_err",    lvl_err,    0);
        check("n_idle_int",   {31'd0, INT_OUT}, 32'd1);
        check("n_idle_frz",   {31'd0, FREEZE},  32'd0);

        // ---- 3. INT_VEC changes during the gap: captured vector holds ---------
        INT_VEC  = 3'd5;
        exp_data = 8'h45;
        do_ack(4, 4, 4, 6, 1'b1, 3'd2);
        check("s_data_err",   data_err,   0);
        check("s_oe_cnt",     oe_cnt,     4);
        check("s_freeze_cnt", freeze_cnt, 12);
        check("s_ack1_cnt",   ack1_cnt,   1);

        // ---- 4. AEOI, vector 0 then vector 6 ----------------------------------
        ICW2     = 8'h08;
        INT_VEC  = 3'd0;
        AEOI     = 1'b1;
        exp_data = 8'h08;
        do_ack(4, 4, 4, 6, 1'b0, 3'd0);
        check("a0_data_err", data_err, 0);
        check("a0_oe_cnt",   oe_cnt,   4);
        check("a0_aeoi_cnt", aeoi_cnt, 1);
        check("a0_aeoi_at",  aeoi_at,  12 + LAT);
        check("a0_aeoi_lvl", {29'd0, aeoi_lvl}, 32'd0);
        check("a0_lvl_err",  lvl_err,  0);

        INT_VEC  = 3'd6;
        exp_data = 8'h0E;
        do_ack(4, 4, 4, 6, 1'b0, 3'd0);
        check("a6_data_err", data_err, 0);
        check("a6_aeoi_cnt", aeoi_cnt, 1);
        check("a6_aeoi_lvl", {29'd0, aeoi_lvl}, 32'd6);
        check("a6_lvl_err",  lvl_err,  0);

        // ---- 5. spurious: INT low at first fall -------------------------------
        INT      = 1'b0;
        INT_VEC  = 3'd1;
        ICW2     = 8'h20;
        AEOI     = 1'b1;
        exp_data = 8'h27;
        do_ack(4, 4, 4, 6, 1'b0, 3'd0);
        check("sp_ack1_cnt", ack1_cnt, 0);
        check("sp_ack2_cnt", ack2_cnt, 1);
        check("sp_aeoi_cnt", aeoi_cnt, 0);
        check("sp_oe_cnt",   oe_cnt,   4);
        check("sp_data_err", data_err, 0);
        check("sp_int_out",  {31'd0, INT_OUT}, 32'd0);

        // ---- 6. reset asserted during P2, then a clean sequence ---------------
        INT      = 1'b1;
        INT_VEC  = 3'd4;
        ICW2     = 8'h40;
        AEOI     = 1'b1;
        exp_data = 8'h44;
        clear_stats();
        INTA_N = 1'b0;
        repeat (4) tick();
        INTA_N = 1'b1;
        repeat (4) tick();
        INTA_N = 1'b0;
        repeat (4) tick();
        check("r_oe_before", {31'd0, DATA_OE}, 32'd1);
        reset = 1'b1;
        #1;
        check("r_oe_async",   {31'd0, DATA_OE},  32'd0);
        check("r_data_async", {24'd0, DATA_OUT}, 32'd0);
        check("r_frz_async",  {31'd0, FREEZE},   32'd0);
        INTA_N = 1'b1;
        tick(); tick();
        reset = 1'b0;
        repeat (4) tick();
        check("r_idle_frz", {31'd0, FREEZE}, 32'd0);
        do_ack(4, 4, 4, 6, 1'b0, 3'd0);
        check("r_ack1_at",   ack1_at,  LAT);
        check("r_ack2_cnt",  ack2_cnt, 1);
        check("r_oe_cnt",    oe_cnt,   4);
        check("r_data_err",  data_err, 0);
        check("r_aeoi_cnt",  aeoi_cnt, 1);
        check("r_aeoi_lvl",  {29'd0, aeoi_lvl}, 32'd4);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/inta_sequencer.md
Name: inta_sequencer

Overview:
- Sits directly downstream of priority_resolver in the 8259A PIC datapath.
- Consumes the resolver's INT/INT_VEC.
- Gates the interrupt request to the CPU and runs the two-pulse INTA acknowledge cycle (8086 mode).
- Produces one-cycle strobes back to the resolver, drives the interrupt vector byte onto the data bus on the second pulse, and issues an automatic EOI when AEOI mode is set.

Parameters:
- SYNC_STAGES, 2, number of flops synchronising the asynchronous INTA_N input (minimum 2).

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- INTA_N  input  1  CPU acknowledge, active-low, asynchronous to clk.
- INT  input  1  pending-interrupt flag from priority_resolver.
- INT_VEC  input  3  winning IR index from priority_resolver.
- ICW2  input  8  vector base; only bits [7:3] used.
- AEOI  input  1  automatic-EOI mode enable (from ICW4).
- INT_OUT  output  1  interrupt request to CPU.
- FREEZE  output  1  high while an acknowledge is in progress; resolver must hold its vector.
- ACK1  output  1  one-cycle strobe: set ISR[vec], clear IRR[vec].
- ACK2  output  1  one-cycle strobe at the start of the second pulse.
- AEOI_STB  output  1  one-cycle strobe requesting non-specific EOI.
- EOI_LEVEL  output  3  IR index accompanying AEOI_STB.
- DATA_OUT  output  8  vector byte.
- DATA_OE  output  1  data bus drive enable.

Behaviour:
- Reset values: all outputs 0; state IDLE; captured vector 3'b000; spurious flag 0; synchroniser flops 1 (INTA_N idle high).
- Synchroniser: INTA_N passes through SYNC_STAGES flops into sync_n, plus one further flop prev_n.
  - fall = prev_n & ~sync_n.
  - rise = ~prev_n & sync_n.
  - Edge-to-action latency is SYNC_STAGES+1 cycles.
- States: IDLE, P1 (first pulse low), GAP (between pulses), P2 (second pulse low).
- IDLE:
  - INT_OUT = INT (registered, 1-cycle latency).
  - On fall: capture vec = INT ? INT_VEC : 3'b111 and spurious = ~INT.
  - Pulse ACK1 for one cycle, suppressed if spurious. Go to P1.
- P1: INT_OUT = 0. On rise, go to GAP. Further falls are ignored.
- GAP: INT_OUT = 0. On fall:
  - Pulse ACK2 for one cycle.
  - Set DATA_OUT = {ICW2[7:3], vec} and DATA_OE = 1.
  - Go to P2.
- P2: DATA_OE stays 1 and DATA_OUT holds. On rise:
  - Clear DATA_OE; DATA_OUT returns to 0 in the same cycle.
  - If AEOI & ~spurious, pulse AEOI_STB for one cycle with EOI_LEVEL = vec.
  - Go to IDLE.
- FREEZE = 1 in P1, GAP and P2; 0 in IDLE.
- Captured vec is immune to INT/INT_VEC changes after capture. ICW2 is sampled live during P2.
- Spurious (INT low at first fall):
  - Full two-pulse cycle still runs.
  - Vector = {ICW2[7:3], 3'b111}.
  - No ACK1 and no AEOI_STB; ACK2 still pulses.
- Rise and fall in the same synchronised sample cannot occur (single sync_n bit).
- A glitch shorter than one clk that is missed by the synchroniser is ignored.
- Reset asserted mid-cycle: immediate return to IDLE, all outputs 0. A later rise or fall from the CPU starts a fresh sequence from IDLE.
- AEOI_STB and EOI_LEVEL are valid only when AEOI_STB = 1. EOI_LEVEL is 0 otherwise.

Decomposition:
- Shared package pic_pkg holds:
  - state enum (IDLE, P1, GAP, P2);
  - VEC_W = 3;
  - SPURIOUS_VEC = 3'b111;
  - 8086 vector-format constant (base bits [7:3]).
- One sub-module: inta_sync (SYNC_STAGES synchroniser plus edge detector producing fall/rise). The FSM lives in inta_sequencer.

Test Plan:
1. Reset then idle: reset=1 mid-operation with INTA_N=1 → all outputs 0, FREEZE=0. Release reset with INT=1, INT_VEC=3 → INT_OUT=1 one cycle later.
2. Normal cycle: ICW2=8'h40, INT=1, INT_VEC=3'd5, AEOI=0, two INTA_N low pulses of 4 cycles each →
   - ACK1 high exactly 1 cycle, SYNC_STAGES+1 after the first fall;
   - INT_OUT=0 from P1 onward;
   - DATA_OE=1 with DATA_OUT=8'h45 throughout the second pulse;
   - no AEOI_STB.
3. Vector stability: change INT_VEC from 5 to 2 during GAP → DATA_OUT still 8'h45, FREEZE=1 through P1..P2.
4. AEOI: ICW2=8'h08, INT_VEC=0, AEOI=1, full cycle → DATA_OUT=8'h08; AEOI_STB one cycle after second rise detected with EOI_LEVEL=0.
5. Spurious: INT=0 at first fall, ICW2=8'h20, AEOI=1 → ACK1 never pulses, DATA_OUT=8'h27, AEOI_STB never pulses, ACK2 pulses once.
6. Reset mid-sequence: assert reset during P2 → DATA_OE=0 and DATA_OUT=0 asynchronously. After release with INTA_N=1, state IDLE and the next pair of pulses completes normally.
